// File: rtl/rec_pkg.sv
// Shared record types for the packed-record writers and the receive-side unpacker.
// The reserved-bit helper is used only when STRUCT_UNPACKER_CHECK_EN is defined.
package rec_pkg;

  typedef logic [7:0] first_t;
  typedef logic [6:0] second_t;
  typedef logic [5:0] third_t;

  typedef struct packed {
    first_t  first;
    second_t second;
    third_t  third;
  } rec_t;

  localparam int REC_BYTES = 3;

  // Byte-index state; the last index is the final byte of a record.
  typedef enum logic [1:0] {
    S_B0 = 2'd0,
    S_B1 = 2'd1,
    S_B2 = 2'(REC_BYTES - 1)
  } state_t;

  function automatic logic rsv_violation(input logic b1_rsv, input logic [1:0] b2_rsv);
    return b1_rsv | (|b2_rsv);
  endfunction

endpackage

// File: rtl/rec_out_reg.sv
// Single-entry output holding register with valid/ready handshake.
// With STRUCT_UNPACKER_CHECK_EN the reserved-bit error travels with the record.
module rec_out_reg
  import rec_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  rec_t rec_in,
`ifdef STRUCT_UNPACKER_CHECK_EN
  input  logic err_in,
  output logic err_out,
`endif
  input  logic out_ready,
  output logic out_valid,
  output rec_t rec_out
);

  logic valid_r;
  rec_t rec_r;
`ifdef STRUCT_UNPACKER_CHECK_EN
  logic err_r;
`endif

  // Load wins over a same-cycle handshake so back-to-back records never bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      rec_r   <= '{first: 8'd0, second: 7'd0, third: 6'd0};
`ifdef STRUCT_UNPACKER_CHECK_EN
      err_r   <= 1'b0;
`endif
    end else if (load) begin
      valid_r <= 1'b1;
      rec_r   <= rec_in;
`ifdef STRUCT_UNPACKER_CHECK_EN
      err_r   <= err_in;
`endif
    end else if (valid_r && out_ready) begin
      valid_r <= 1'b0;
      rec_r   <= rec_r;
`ifdef STRUCT_UNPACKER_CHECK_EN
      err_r   <= 1'b0;
`endif
    end else begin
      valid_r <= valid_r;
      rec_r   <= rec_r;
`ifdef STRUCT_UNPACKER_CHECK_EN
      err_r   <= err_r;
`endif
    end
  end

  assign out_valid = valid_r;
  assign rec_out   = rec_r;
`ifdef STRUCT_UNPACKER_CHECK_EN
  assign err_out   = err_r;
`endif

endmodule

// File: rtl/struct_unpacker.sv
// Reassembles 3-byte records from a byte stream and presents them on a valid/ready output.
// Define STRUCT_UNPACKER_CHECK_EN to add the out_err reserved-bit flag.
module struct_unpacker
  import rec_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_first,
  output logic [6:0]       out_second,
  output logic [5:0]       out_third,
`ifdef STRUCT_UNPACKER_CHECK_EN
  output logic             out_err,
`endif
  output logic [CNT_W-1:0] rec_count
);

  state_t            state_r;
  state_t            state_next_s;
  first_t            first_r;
  second_t           second_r;
  logic              in_ready_s;
  logic              accept_s;
  logic              load_s;
  logic              out_valid_s;
  rec_t              rec_in_s;
  rec_t              rec_out_s;
  logic [CNT_W-1:0]  rec_count_r;
`ifdef STRUCT_UNPACKER_CHECK_EN
  logic              rsv1_r;
  logic              err_in_s;
  logic              err_out_s;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_B0;
    else     state_r <= state_next_s;
  end

  // Next-state: flush overrides any byte accepted in the same cycle.
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = S_B0;
    end else if (accept_s) begin
      case (state_r)
        S_B0:    state_next_s = S_B1;
        S_B1:    state_next_s = S_B2;
        S_B2:    state_next_s = S_B0;
        default: state_next_s = S_B0;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Handshake decode: only the last byte waits for room in the output register.
  always_comb begin
    in_ready_s = 1'b1;
    case (state_r)
      S_B2:    in_ready_s = !out_valid_s || out_ready;
      default: in_ready_s = 1'b1;
    endcase
    accept_s = in_valid && in_ready_s;
    load_s   = accept_s && !flush && (state_r == S_B2);
  end

  // Staging for B0/B1; reserved bits kept only when checking is enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_r  <= 8'd0;
      second_r <= 7'd0;
`ifdef STRUCT_UNPACKER_CHECK_EN
      rsv1_r   <= 1'b0;
`endif
    end else if (accept_s && !flush) begin
      case (state_r)
        S_B0: first_r <= in_data;
        S_B1: begin
          second_r <= in_data[6:0];
`ifdef STRUCT_UNPACKER_CHECK_EN
          rsv1_r   <= in_data[7];
`endif
        end
        default: first_r <= first_r;
      endcase
    end else begin
      first_r <= first_r;
    end
  end

  // Delivered-record counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)                          rec_count_r <= {CNT_W{1'b0}};
    else if (out_valid_s && out_ready) rec_count_r <= rec_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    else                              rec_count_r <= rec_count_r;
  end

  assign rec_in_s = '{first: first_r, second: second_r, third: in_data[5:0]};
`ifdef STRUCT_UNPACKER_CHECK_EN
  assign err_in_s = rsv_violation(rsv1_r, in_data[7:6]);
`endif

  rec_out_reg u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .rec_in    (rec_in_s),
`ifdef STRUCT_UNPACKER_CHECK_EN
    .err_in    (err_in_s),
    .err_out   (err_out_s),
`endif
    .out_ready (out_ready),
    .out_valid (out_valid_s),
    .rec_out   (rec_out_s)
  );

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_s;
  assign out_first  = rec_out_s.first;
  assign out_second = rec_out_s.second;
  assign out_third  = rec_out_s.third;
  assign rec_count  = rec_count_r;
`ifdef STRUCT_UNPACKER_CHECK_EN
  assign out_err    = err_out_s;
`endif

endmodule

// File: doc/struct_unpacker.md
# struct_unpacker

Receive-side counterpart of the packed-record writers in the design. Accepts a byte stream over a valid/ready handshake, reassembles each 3-byte record into the shared record fields (`first` 8 b, `second` 7 b, `third` 6 b), and presents one complete record per output handshake. Sits between the byte-wide link interface and consumers of the record fields.

## Interface
- `CNT_W`, 16: width of the accepted-record counter.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  byte available.
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`.
- `in_data`  in  8  stream byte.
- `flush`  in  1  discard the partial record; the next accepted byte is byte 0.
- `out_valid`  out  1  record held.
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`.
- `out_first`  out  8  record field `first`.
- `out_second`  out  7  record field `second`.
- `out_third`  out  6  record field `third`.
- `rec_count`  out  `CNT_W`  records delivered; wraps modulo 2^`CNT_W`.
- `out_err`  out  1  reserved-bit violation in the held record (present only with `STRUCT_UNPACKER_CHECK_EN`).

## Operation
- Byte order per record: B0 = `first[7:0]`; B1 = {rsv, `second[6:0]`}; B2 = {rsv[1:0], `third[5:0]`}. Reserved bits are dropped.
- Byte-index state: `S_B0` → `S_B1` → `S_B2` → `S_B0`. A state advances only on an accepted byte.
- B0 and B1 go to staging registers. Accepting B2 loads the output register with {staged `first`, staged `second`, B2[5:0]} and sets `out_valid`.
- `in_ready` = 1 in `S_B0`/`S_B1`. In `S_B2`, `in_ready` = `!out_valid || out_ready`. While the previous record waits, B0 and B1 of the next record are still accepted.
- `out_valid` clears on an output handshake unless a new B2 is accepted in the same cycle. In that case the output reloads and `out_valid` stays 1.
- `rec_count` increments by 1 on each output handshake. It wraps 2^`CNT_W`−1 → 0.
- `flush`: state → `S_B0` next cycle. Any byte accepted in the flush cycle is discarded. The held output record and `rec_count` are unaffected.
- Reset values: state `S_B0`; `out_valid` 0; `out_first`/`out_second`/`out_third` 0; `rec_count` 0; `out_err` 0; staging 0. `in_ready` is 1 the first cycle after reset.
- Reset mid-record: the partial record is lost and the held output is dropped. Nothing is delivered.

## Timing
- Latency: `out_valid` rises the cycle after B2 is accepted.
- Throughput: one byte per cycle, so one record per 3 cycles, with `out_ready` held high.
- No combinational path from `in_valid`/`in_data` to any output.
- `in_ready` depends combinationally on `out_ready` in `S_B2` only.
- Output fields are stable while `out_valid && !out_ready`.

## Configuration
- `STRUCT_UNPACKER_CHECK_EN` defined:
  - `out_err` port exists.
  - `out_err` is registered with the record and set if B1[7] != 0 or B2[7:6] != 0.
  - `out_err` is cleared with `out_valid`.
  - The record is still delivered.
- Not defined: `out_err` port and its checking logic are absent; reserved bits are silently ignored.

## Structure
- Shared package `rec_pkg` holds:
  - typedefs `first_t` (logic [7:0]), `second_t` (logic [6:0]), `third_t` (logic [5:0]);
  - packed struct `rec_t` {`first`, `second`, `third`};
  - the state enum;
  - localparam `REC_BYTES` = 3.
- Natural sub-module: `rec_out_reg`, the single-entry output holding register with valid/ready and error bit. Byte sequencing stays in the top.

## Test plan
- Basic record: after reset, bytes 0xFF, 0x7F, 0x3F with `out_ready`=1 → `out_first`=255, `out_second`=127, `out_third`=63; `out_valid` one cycle after the third byte; `rec_count`=1.
- Back-pressure: `out_ready`=0, send two records (0x01,0x02,0x03 then 0x04,0x05,0x06):
  - `in_ready` drops only at the 6th byte;
  - first record held stable;
  - raising `out_ready` delivers 1/2/3, then 4/5/6.
- Flush: send 0xAA, 0xBB, pulse `flush`, then 0x11, 0x22, 0x33 → exactly one record, 0x11/0x22/0x33.
- Reserved bits: bytes 0x10, 0x85, 0xC7 → `second`=0x05, `third`=0x07. With `STRUCT_UNPACKER_CHECK_EN`, `out_err`=1; with 0x10, 0x05, 0x07, `out_err`=0.
- Counter wrap: `CNT_W`=2, deliver 5 records → `rec_count` sequence 1, 2, 3, 0, 1.
- Reset mid-record: assert `rst` after B1, then release → `out_valid`=0, `rec_count`=0; the next 3 bytes form a full record.
